// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a 2-entry valid/ready stream buffer (FIFO_RD_CNT_EN adds rd_count).
// Latency: rd_en in cycle N gives m_valid in cycle N+2 when the buffer is empty; one word per cycle in steady state.
// Backpressure: with m_ready low, popping stops once buffered plus in-flight words reach two.
module fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_rd,
  input  logic             rst,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             flag_empty,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count
`endif
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             pop;
  logic [2:0]       slots;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];
  assign pop     = m_valid && m_ready;

  always_comb begin
    // Occupancy after this edge: buffered plus in-flight minus the word leaving now.
    slots      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = !rst && !flag_empty && (slots < 3'd2);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = slots[1:0];
    inflight_d = rd_en;
    if (inflight_q) begin
      mem_d[wr_ptr_q] = rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign rd_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based model of FIFO, in-flight word and output buffer, checked every cycle.
module tb_fifo_rd_stream;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk_rd = 1'b0;
  logic         rst;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         flag_empty;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] rd_count;
`endif

  always #5 clk_rd = ~clk_rd;

  fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_rd     (clk_rd),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .flag_empty (flag_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] buf_q[$];
  logic [W-1:0] flight_q[$];
  logic [W-1:0] obs_q[$];
  bit           force_empty;
  int           cnt_m;
  int           cyc;
  int           n_tests;
  int           n_fail;
  int           en_cnt, vld_cnt, first_en, first_vld, last_vld;
  logic [W-1:0] first_vld_dat;
  bit           last_rd_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    obs_q.delete();
    en_cnt = 0; vld_cnt = 0; first_en = -1; first_vld = -1; last_vld = -1;
    first_vld_dat = '0;
  endtask

  // Called at the falling edge: drive inputs, compare outputs, advance model across the next rising edge.
  task automatic cycle(input bit rdy);
    bit exp_pop, exp_en;
    int pend;
    if (rst) begin
      buf_q.delete(); flight_q.delete(); cnt_m = 0;
    end
    m_ready    = rdy;
    flag_empty = (fifo_q.size() == 0) || force_empty;
    rd_data    = (flight_q.size() != 0) ? flight_q[0] : W'($urandom);
    #1;
    exp_pop = !rst && (buf_q.size() != 0) && rdy;
    pend    = buf_q.size() + flight_q.size() - int'(exp_pop);
    exp_en  = !rst && !flag_empty && (pend < 2);
    check("rd_en", 32'(rd_en), 32'(exp_en));
    check("m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) check("m_data", 32'(m_data), 32'(buf_q[0]));
    if (rst) check("m_data_rst", 32'(m_data), 32'h0);
`ifdef FIFO_RD_CNT_EN
    check("rd_count", 32'(rd_count), 32'(cnt_m % 16));
`endif
    last_rd_en = rd_en;
    if (rd_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
    end
    if (m_valid) begin
      vld_cnt++;
      if (first_vld < 0) begin
        first_vld = cyc; first_vld_dat = m_data;
      end
      last_vld = cyc;
      if (m_ready && !rst) obs_q.push_back(m_data);
    end
    if (exp_pop) begin
      void'(buf_q.pop_front());
      cnt_m++;
    end
    if (flight_q.size() != 0) buf_q.push_back(flight_q.pop_front());
    if (exp_en && fifo_q.size() != 0) flight_q.push_back(fifo_q.pop_front());
    @(posedge clk_rd);
    @(negedge clk_rd);
    cyc++;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(rdy);
  endtask

  logic [W-1:0] exp5 [5];

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; cnt_m = 0; force_empty = 0;
    rst = 1'b1; m_ready = 1'b0; flag_empty = 1'b1; rd_data = '0;
    @(negedge clk_rd);
    run(2, 1'b0);
    rst = 1'b0;
    run(2, 1'b1);

    // Single word: rd_en at N, m_valid with the word at N+2 for exactly one cycle.
    clear_stats();
    fifo_q.push_back(8'hA1);
    run(6, 1'b1);
    check("t1_latency", 32'(first_vld - first_en), 32'd2);
    check("t1_vld_cnt", 32'(vld_cnt), 32'd1);
    check("t1_data", 32'(first_vld_dat), 32'hA1);
    check("t1_rd_en_cnt", 32'(en_cnt), 32'd1);

    // Backpressure: five words waiting, only two popped while m_ready is low.
    clear_stats();
    exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) fifo_q.push_back(exp5[i]);
    run(6, 1'b0);
    check("t2_rd_en_pulses", 32'(en_cnt), 32'd2);
    check("t2_hold_valid", 32'(m_valid), 32'd1);
    check("t2_hold_data", 32'(m_data), 32'h11);
    run(10, 1'b1);
    check("t2_count", 32'(obs_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) check("t2_order", 32'(obs_q[i]), 32'(exp5[i]));

    // Continuous stream: m_valid every cycle after the fill.
    clear_stats();
    for (int i = 0; i < 64; i++) fifo_q.push_back(W'(i));
    run(70, 1'b1);
    check("t3_vld_cnt", 32'(vld_cnt), 32'd64);
    check("t3_no_gaps", 32'(last_vld - first_vld + 1), 32'd64);
    check("t3_fill", 32'(first_vld - first_en), 32'd2);
    check("t3_count", 32'(obs_q.size()), 32'd64);
    for (int i = 0; i < 64 && i < obs_q.size(); i++) check("t3_order", 32'(obs_q[i]), 32'(i));

    // Empty flag rises while a word is in flight.
    clear_stats();
    fifo_q.push_back(8'h77);
    fifo_q.push_back(8'h88);
    cycle(1'b1);
    check("t4_first_en", 32'(last_rd_en), 32'd1);
    force_empty = 1'b1;
    cycle(1'b1);
    check("t4_forced_off", 32'(last_rd_en), 32'd0);
    force_empty = 1'b0;
    run(6, 1'b1);
    check("t4_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("t4_w0", 32'(obs_q[0]), 32'h77);
      check("t4_w1", 32'(obs_q[1]), 32'h88);
    end

    // Asynchronous reset with the buffer full.
    clear_stats();
    fifo_q.push_back(8'h91);
    fifo_q.push_back(8'h92);
    run(5, 1'b0);
    check("t5_full_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(m_valid), 32'd0);
    check("t5_async_data", 32'(m_data), 32'h0);
    check("t5_async_rd_en", 32'(rd_en), 32'd0);
    buf_q.delete(); flight_q.delete(); fifo_q.delete(); cnt_m = 0;
    run(2, 1'b0);
    rst = 1'b0;
    clear_stats();
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'hA6);
    run(8, 1'b1);
    check("t5_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check("t5_w0", 32'(obs_q[0]), 32'hA5);
      check("t5_w1", 32'(obs_q[1]), 32'hA6);
    end

`ifdef FIFO_RD_CNT_EN
    // Counter wrap: 17 pops into a 4-bit counter leaves 1.
    rst = 1'b1;
    run(2, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(W'(8'hC0 + i));
    run(30, 1'b1);
    check("t6_rd_count_wrap", 32'(rd_count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter CNT_W, default 16: width of the delivered-word counter.
REQ-003 clk_rd  input  1  read-domain clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rd_en  output  1  pop request to the asynchronous FIFO read port.
REQ-006 rd_data  input  WIDTH  FIFO read data, valid on the cycle after the rd_en cycle.
REQ-007 flag_empty  input  1  FIFO empty flag, already in the clk_rd domain.
REQ-008 m_data  output  WIDTH  downstream stream data.
REQ-009 m_valid  output  1  downstream data valid.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 rd_count  output  CNT_W  words delivered downstream; present only with FIFO_RD_CNT_EN.

Function
REQ-012 Block SHALL hold a 2-entry in-order output buffer with occupancy occ in 0..2, plus a 1-bit inflight flag.
REQ-013 Downstream transfer (pop) SHALL occur on an edge where m_valid and m_ready are both 1.
REQ-014 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word, stable while m_valid is 1 and m_ready is 0.
REQ-015 rd_en SHALL be combinational: 1 when !rst, !flag_empty, and (occ + inflight - pop) < 2; otherwise 0.
REQ-016 inflight SHALL register rd_en every cycle.
REQ-017 When inflight is 1, rd_data SHALL be written into the buffer at that edge.
REQ-018 Simultaneous capture and pop SHALL leave occ unchanged and preserve word order.
REQ-019 Buffer full (occ=2, or occ=1 with inflight=1 and no pop): rd_en SHALL be 0, and no word SHALL be lost or overwritten.
REQ-020 flag_empty=1 SHALL force rd_en to 0 in the same cycle; an already in-flight word SHALL still be captured.
REQ-021 Latency: rd_en high in cycle N SHALL give m_valid high with that word from cycle N+2 when the buffer was empty.
REQ-022 Throughput: with m_ready held 1 and flag_empty held 0, rd_en and m_valid SHALL each be 1 every cycle in steady state.
REQ-023 Buffer pointers SHALL wrap modulo 2.

Reset
REQ-024 While rst is 1: occ=0, inflight=0, m_valid=0, m_data=0, rd_en=0, rd_count=0.
REQ-025 Reset asserted mid-operation SHALL discard buffered and in-flight words immediately (asynchronous).
REQ-026 After rst deasserts, rd_en SHALL assert no earlier than the first following edge with flag_empty=0.

Configuration
REQ-027 Macro FIFO_RD_CNT_EN defined: rd_count SHALL increment by 1 on each pop and wrap modulo 2^CNT_W.
REQ-028 Macro FIFO_RD_CNT_EN undefined: the rd_count port and its counter SHALL be absent.

Verification
REQ-029 FIFO holds 0xA1 (flag_empty=0 for one read), m_ready=1 -> rd_en pulses in cycle N; m_valid=1 with m_data=0xA1 in cycle N+2 for one cycle.
REQ-030 m_ready=0, FIFO holds 5 words -> exactly 2 rd_en pulses, occ=2, m_data holds word 1; m_ready=1 -> words 1..5 delivered in order, no duplicates or gaps.
REQ-031 Continuous stream 0x00..0x3F with m_ready=1 -> after a 2-cycle fill, m_valid=1 on every cycle; output order matches input order.
REQ-032 flag_empty rises in the same cycle inflight=1 -> rd_en=0 that cycle; the in-flight word is still delivered.
REQ-033 rst pulsed while occ=2 -> m_valid=0 immediately; after release, old words never appear and new words deliver normally.
REQ-034 With FIFO_RD_CNT_EN and CNT_W=4, 17 pops -> rd_count reads 1 (wrapped).
